// File: rtl/sequence_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector:
// serializer state, detector state encodings and the default word width.
package sequence_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_t;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } det_state_t;

  localparam int SEQ_WORD_W = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the sequence detector, MSB first by default.
// Define BIT_SERIALIZER_LSB_FIRST_EN to emit words LSB first instead.
module bit_serializer
  import sequence_pkg::*;
#(
  parameter int  WIDTH = SEQ_WORD_W,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state, next_state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic             at_end;
  logic             take;

  assign at_end = (cnt == '0);
  assign take   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (take) next_state = ST_SHIFT;
      ST_SHIFT: if (at_end && !take) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Reloading on the last bit keeps the stream gap-free across word boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (take) begin
      sr  <= in_data;
      cnt <= CNT_LAST;
    end else if (state == ST_SHIFT && !at_end) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      sr  <= {1'b0, sr[WIDTH-1:1]};
`else
      sr  <= {sr[WIDTH-2:0], 1'b0};
`endif
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    in_ready = (state == ST_IDLE) || at_end;
    x        = 1'b0;
    x_valid  = 1'b0;
    last_bit = 1'b0;
    busy     = 1'b0;
    if (state == ST_SHIFT) begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      x        = sr[0];
`else
      x        = sr[WIDTH-1];
`endif
      x_valid  = 1'b1;
      last_bit = at_end;
      busy     = 1'b1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed table-driven bench for bit_serializer; honours BIT_SERIALIZER_LSB_FIRST_EN
// by reversing the expected bit order of every word.
module tb_bit_serializer;
  import sequence_pkg::*;

  localparam int WIDTH = SEQ_WORD_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             last_bit;
  logic             busy;

  bit_serializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x        (x),
    .x_valid  (x_valid),
    .last_bit (last_bit),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // One row per clock cycle: inputs driven during the cycle, outputs expected in it.
  // exp packs {x, x_valid, last_bit, in_ready, busy}.
  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       chk;
    logic [4:0] exp;
  } vec_t;

  localparam logic [4:0] IDLE_EXP = 5'b00010;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Bit order in which a word appears on x, read from index 7 down to 0.
  function automatic logic [7:0] ord(input logic [7:0] w);
    logic [7:0] r;
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic push(input logic r, input logic v, input logic [7:0] d,
                      input logic chk, input logic [4:0] exp);
    vec_t t;
    t.rst = r; t.v = v; t.d = d; t.chk = chk; t.exp = exp;
    vecs.push_back(t);
  endtask

  // Eight rows streaming word w; from row v_from onward the next word nxt is offered.
  task automatic shift_rows(input logic [7:0] w, input int v_from, input logic [7:0] nxt);
    logic [7:0] o;
    o = ord(w);
    for (int i = 0; i < 8; i++)
      push(1'b0, i >= v_from, (i >= v_from) ? nxt : 8'h00, 1'b1,
           {o[7-i], 1'b1, i == 7, i == 7, 1'b1});
  endtask

  initial begin
    logic [7:0] b0o;
    logic [4:0] rst_got;
    int         waited;
    b0o = ord(8'hB0);

    // Direct reset-state check
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    rst_got = {x, x_valid, last_bit, in_ready, busy};
    checks++;
    if (rst_got !== IDLE_EXP) begin
      errors++;
      $display("FAIL reset state {x,x_valid,last_bit,in_ready,busy} got %b want %b",
               rst_got, IDLE_EXP);
    end

    // Reset state
    push(1'b1, 1'b0, 8'h00, 1'b0, IDLE_EXP);
    push(1'b1, 1'b0, 8'h00, 1'b1, IDLE_EXP);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // Single word B0, one-cycle in_valid pulse while idle
    push(1'b0, 1'b1, 8'hB0, 1'b1, IDLE_EXP);
    shift_rows(8'hB0, 8, 8'h00);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // Back-to-back 05 then B0 with in_valid held high
    push(1'b0, 1'b1, 8'h05, 1'b1, IDLE_EXP);
    shift_rows(8'h05, 0, 8'hB0);
    shift_rows(8'hB0, 8, 8'h00);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // FF offered from cycle 3 is only taken on the last bit
    push(1'b0, 1'b1, 8'hB0, 1'b1, IDLE_EXP);
    shift_rows(8'hB0, 2, 8'hFF);
    shift_rows(8'hFF, 8, 8'h00);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // Reset at edge 4 mid-word, then 0B from scratch
    push(1'b0, 1'b1, 8'hB0, 1'b1, IDLE_EXP);
    for (int i = 0; i < 3; i++)
      push(1'b0, 1'b0, 8'h00, 1'b1, {b0o[7-i], 4'b1001});
    push(1'b1, 1'b1, 8'hFF, 1'b1, {b0o[4], 4'b1001});
    push(1'b0, 1'b1, 8'h0B, 1'b1, IDLE_EXP);
    shift_rows(8'h0B, 8, 8'h00);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // Transfer offered while reset is high in idle is discarded
    push(1'b1, 1'b1, 8'hFF, 1'b1, IDLE_EXP);
    push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    // Single word 0D (LSB-first scenario when the feature is on)
    push(1'b0, 1'b1, 8'h0D, 1'b1, IDLE_EXP);
    shift_rows(8'h0D, 8, 8'h00);

    // in_valid low: line stays idle
    for (int i = 0; i < 6; i++) push(1'b0, 1'b0, 8'h00, 1'b1, IDLE_EXP);

    for (int k = 0; k < vecs.size(); k++) begin
      logic [4:0] got;
      @(negedge clk);
      rst      = vecs[k].rst;
      in_valid = vecs[k].v;
      in_data  = vecs[k].d;
      #1;
      got = {x, x_valid, last_bit, in_ready, busy};
      if (vecs[k].chk) begin
        checks++;
        if (got !== vecs[k].exp) begin
          errors++;
          $display("FAIL row %0d {x,x_valid,last_bit,in_ready,busy} got %b want %b",
                   k, got, vecs[k].exp);
        end
      end
    end

    // Bounded wait for the last bit of a freshly accepted word
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hB0;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    waited = 0;
    while (last_bit !== 1'b1 && waited < WIDTH + 4) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (last_bit !== 1'b1) begin
      errors++;
      $display("FAIL wait for last_bit expired after %0d cycles", waited);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
